// File: rtl/apb_mem_slave.sv
// ----------------------------------------------------------------------------
// apb_mem_slave
//   APB completer that fronts a synchronous single-port memory.
//   Setup latches the request. A programmable number of wait cycles follows.
//   One MEM cycle then issues the memory strobe, and one RESP cycle raises
//   ready. Out-of-range or misaligned requests skip MEM and respond with
//   slverr.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   sel, enable, write, strb,
//   addr, wdata                     APB request
//   ready, slverr, rdata            APB response (valid while ready=1)
//   mem_wr, mem_rd, mem_be,
//   mem_address, mem_data_in        memory request (registered)
//   mem_data_out                    memory read data, one cycle after mem_rd
// ----------------------------------------------------------------------------
module apb_mem_slave #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    MEM_WORDS   = 1024,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sel,
  input  logic                    enable,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] strb,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    ready,
  output logic                    slverr,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    mem_wr,
  output logic                    mem_rd,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_data_in,
  input  logic [DATA_WIDTH-1:0]   mem_data_out
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFS = $clog2(NB);

  // One extra bit so the end-of-window bound cannot wrap.
  localparam logic [ADDR_WIDTH:0]   LIMIT      = {1'b0, BASE_ADDR} +
                                                 (ADDR_WIDTH+1)'(MEM_WORDS * NB);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NB - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MEM, S_RESP} state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic                    r_write;
  logic                    r_err;
  logic [NB-1:0]           r_strb;
  logic                    r_ready;
  logic                    r_slverr;
  logic                    r_rd_ok;
  logic                    r_mem_wr;
  logic                    r_mem_rd;
  logic [NB-1:0]           r_mem_be;
  logic [ADDR_WIDTH-1:0]   r_mem_address;
  logic [DATA_WIDTH-1:0]   r_mem_data_in;

  logic                    w_err;
  logic [ADDR_WIDTH-1:0]   w_idx;

  assign w_err = (addr < BASE_ADDR) || ({1'b0, addr} >= LIMIT) ||
                 ((addr & ALIGN_MASK) != '0);
  assign w_idx = (addr - BASE_ADDR) >> OFS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_write       <= 1'b0;
      r_err         <= 1'b0;
      r_strb        <= '0;
      r_ready       <= 1'b0;
      r_slverr      <= 1'b0;
      r_rd_ok       <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_be      <= '0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
    end else begin
      // Strobes and response flags are single-cycle pulses by default.
      r_ready  <= 1'b0;
      r_slverr <= 1'b0;
      r_rd_ok  <= 1'b0;
      r_mem_wr <= 1'b0;
      r_mem_rd <= 1'b0;
      r_mem_be <= '0;
      case (r_state)
        S_IDLE: begin
          if (sel && !enable) begin
            r_write       <= write;
            r_err         <= w_err;
            r_strb        <= strb;
            r_mem_address <= w_idx;
            r_mem_data_in <= wdata;
            r_cnt         <= 4'(WAIT_STATES);
            r_state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!sel) begin
            r_state <= S_IDLE;                // master aborted
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 4'd1;
          end else if (r_err) begin
            r_state  <= S_RESP;
            r_ready  <= 1'b1;
            r_slverr <= 1'b1;
          end else begin
            r_state <= S_MEM;
            if (r_write) begin
              // An all-zero strobe write completes without touching memory.
              r_mem_wr <= |r_strb;
              r_mem_be <= r_strb;
            end else begin
              r_mem_rd <= 1'b1;
              r_mem_be <= '1;
            end
          end
        end
        S_MEM: begin
          if (!sel) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_RESP;
            r_ready <= 1'b1;
            r_rd_ok <= !r_write;
          end
        end
        default: r_state <= S_IDLE;         // S_RESP lasts one cycle
      endcase
    end
  end

  assign ready       = r_ready;
  assign slverr      = r_slverr;
  // Memory data only arrives in the RESP cycle, so it is gated, not flopped.
  assign rdata       = r_rd_ok ? mem_data_out : '0;
  assign mem_wr      = r_mem_wr;
  assign mem_rd      = r_mem_rd;
  assign mem_be      = r_mem_be;
  assign mem_address = r_mem_address;
  assign mem_data_in = r_mem_data_in;

endmodule

// File: tb/tb_apb_mem_slave.sv
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // Instance 0: WAIT_STATES=2, instance 1: WAIT_STATES=0.
  logic        sel    [2];
  logic        enable [2];
  logic        write  [2];
  logic [3:0]  strb   [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        ready  [2];
  logic        slverr [2];
  logic [31:0] rdata  [2];
  logic        mem_wr [2];
  logic        mem_rd [2];
  logic [3:0]  mem_be [2];
  logic [31:0] mem_address [2];
  logic [31:0] mem_data_in [2];
  logic [31:0] mdo    [2];

  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(32'h1000),
                  .MEM_WORDS(1024), .WAIT_STATES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sel(sel[0]), .enable(enable[0]),
    .write(write[0]), .strb(strb[0]), .addr(addr[0]), .wdata(wdata[0]),
    .ready(ready[0]), .slverr(slverr[0]), .rdata(rdata[0]),
    .mem_wr(mem_wr[0]), .mem_rd(mem_rd[0]), .mem_be(mem_be[0]),
    .mem_address(mem_address[0]), .mem_data_in(mem_data_in[0]),
    .mem_data_out(mdo[0]));

  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(32'h1000),
                  .MEM_WORDS(1024), .WAIT_STATES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sel(sel[1]), .enable(enable[1]),
    .write(write[1]), .strb(strb[1]), .addr(addr[1]), .wdata(wdata[1]),
    .ready(ready[1]), .slverr(slverr[1]), .rdata(rdata[1]),
    .mem_wr(mem_wr[1]), .mem_rd(mem_rd[1]), .mem_be(mem_be[1]),
    .mem_address(mem_address[1]), .mem_data_in(mem_data_in[1]),
    .mem_data_out(mdo[1]));

  // Synchronous byte-enabled memories behind each instance.
  logic [31:0] mem [2][1024];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_wr[i])
        for (int b = 0; b < 4; b++)
          if (mem_be[i][b]) mem[i][mem_address[i][9:0]][8*b +: 8] <= mem_data_in[i][8*b +: 8];
      if (mem_rd[i]) mdo[i] <= mem[i][mem_address[i][9:0]];
    end
  end

  // Strobe monitor, sampled mid-cycle.
  int          wr_cnt [2];
  int          rd_cnt [2];
  logic [31:0] last_addr [2];
  logic [3:0]  last_be   [2];
  logic [31:0] last_wd   [2];
  initial for (int i = 0; i < 2; i++) begin wr_cnt[i] = 0; rd_cnt[i] = 0; end
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_wr[i]) begin wr_cnt[i]++; last_wd[i] = mem_data_in[i]; end
      if (mem_rd[i]) rd_cnt[i]++;
      if (mem_wr[i] || mem_rd[i]) begin last_addr[i] = mem_address[i]; last_be[i] = mem_be[i]; end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rd;
    int          nwr;
    int          nrd;
  } exp_t;
  exp_t sb[$];

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One APB transfer; enters at #1 into the cycle before setup and leaves
  // in the RESP cycle so the next call can issue a back-to-back setup.
  task automatic xfer(input int b, input string tag, input bit wr,
                      input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                      input int lat, input bit err, input logic [31:0] rd,
                      input int nwr, input int nrd);
    exp_t e, got;
    int   t0, w0, r0;
    bit   seen;
    e.lat = lat; e.err = err; e.rd = rd; e.nwr = nwr; e.nrd = nrd;
    step();
    sel[b] = 1'b1; enable[b] = 1'b0; write[b] = wr; addr[b] = a; wdata[b] = wd; strb[b] = st;
    sb.push_back(e);
    t0 = cyc; w0 = wr_cnt[b]; r0 = rd_cnt[b];
    step();
    enable[b] = 1'b1;
    // Scramble request fields after setup; the slave must ignore them.
    addr[b] = 32'h0; wdata[b] = 32'h0BAD_0BAD; strb[b] = 4'hF; write[b] = ~wr;
    seen = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (ready[b]) begin seen = 1'b1; break; end
      step();
    end
    got = sb.pop_front();
    if (!seen) begin
      chk({tag, " ready_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({tag, " latency"}, 64'(cyc - t0), 64'(got.lat));
      chk({tag, " slverr"}, 64'(slverr[b]), 64'(got.err));
      chk({tag, " rdata"}, 64'(rdata[b]), 64'(got.rd));
      chk({tag, " mem_wr_pulses"}, 64'(wr_cnt[b] - w0), 64'(got.nwr));
      chk({tag, " mem_rd_pulses"}, 64'(rd_cnt[b] - r0), 64'(got.nrd));
    end
  endtask

  task automatic go_idle(input int b);
    step();
    sel[b] = 1'b0; enable[b] = 1'b0;
  endtask

  initial begin
    int t0, w0;
    bit any_ready;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sel[i] = 0; enable[i] = 0; write[i] = 0; strb[i] = 0; addr[i] = 0; wdata[i] = 0;
    end
    #3;
    chk("reset ready",  64'(ready[0]),  64'd0);
    chk("reset slverr", 64'(slverr[0]), 64'd0);
    chk("reset rdata",  64'(rdata[0]),  64'd0);
    chk("reset strobes", 64'({mem_wr[0], mem_rd[0], mem_be[0]}), 64'd0);
    chk("reset mem_address", 64'(mem_address[0]), 64'd0);
    step(); step();
    rst_n = 1'b1;

    // Full write then read back.
    xfer(0, "wr_1008", 1'b1, 32'h1008, 32'hDEADBEEF, 4'hF, 5, 1'b0, 32'h0, 1, 0);
    chk("wr_1008 mem_address", 64'(last_addr[0]), 64'd2);
    chk("wr_1008 mem_be", 64'(last_be[0]), 64'hF);
    chk("wr_1008 mem_data_in", 64'(last_wd[0]), 64'hDEADBEEF);
    xfer(0, "rd_1008", 1'b0, 32'h1008, 32'h0, 4'h0, 5, 1'b0, 32'hDEADBEEF, 0, 1);
    chk("rd_1008 mem_be", 64'(last_be[0]), 64'hF);

    // Error cases.
    xfer(0, "rd_2000_oor", 1'b0, 32'h2000, 32'h0, 4'h0, 4, 1'b1, 32'h0, 0, 0);
    xfer(0, "rd_1002_misal", 1'b0, 32'h1002, 32'h0, 4'h0, 4, 1'b1, 32'h0, 0, 0);
    xfer(0, "wr_0ffc_below", 1'b1, 32'h0FFC, 32'h1, 4'hF, 4, 1'b1, 32'h0, 0, 0);

    // Strobe cases.
    xfer(0, "wr_strb0", 1'b1, 32'h1008, 32'h12345678, 4'h0, 5, 1'b0, 32'h0, 0, 0);
    xfer(0, "wr_strb6", 1'b1, 32'h1008, 32'h11223344, 4'h6, 5, 1'b0, 32'h0, 1, 0);
    chk("wr_strb6 mem_be", 64'(last_be[0]), 64'h6);
    xfer(0, "rd_after_strb6", 1'b0, 32'h1008, 32'h0, 4'h0, 5, 1'b0, 32'hDE2233EF, 0, 1);
    go_idle(0);

    // Abort by dropping sel during WAIT.
    step();
    sel[0] = 1; enable[0] = 0; write[0] = 1; addr[0] = 32'h1010; wdata[0] = 32'hCAFE; strb[0] = 4'hF;
    w0 = wr_cnt[0];
    step(); enable[0] = 1;
    step(); sel[0] = 0; enable[0] = 0;
    any_ready = 0;
    for (int k = 0; k < 8; k++) begin step(); if (ready[0]) any_ready = 1; end
    chk("abort_wait no_ready", 64'(any_ready), 64'd0);
    chk("abort_wait no_mem_wr", 64'(wr_cnt[0] - w0), 64'd0);
    xfer(0, "after_abort", 1'b1, 32'h1010, 32'h55AA55AA, 4'hF, 5, 1'b0, 32'h0, 1, 0);
    go_idle(0);

    // Reset during MEM.
    step();
    sel[0] = 1; enable[0] = 0; write[0] = 1; addr[0] = 32'h1014; wdata[0] = 32'h77; strb[0] = 4'hF;
    t0 = cyc; w0 = wr_cnt[0];
    step(); enable[0] = 1;
    step(); step(); step();
    chk("rst_mem in_mem cycle", 64'(cyc - t0), 64'd4);
    chk("rst_mem mem_wr_before", 64'(mem_wr[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mem async strobes", 64'({mem_wr[0], mem_be[0], ready[0]}), 64'd0);
    chk("rst_mem async mem_address", 64'(mem_address[0]), 64'd0);
    sel[0] = 0; enable[0] = 0;
    step();
    rst_n = 1'b1;
    any_ready = 0;
    for (int k = 0; k < 6; k++) begin step(); if (ready[0]) any_ready = 1; end
    chk("rst_mem no_ready", 64'(any_ready), 64'd0);
    chk("rst_mem no_mem_wr", 64'(wr_cnt[0] - w0), 64'd0);
    xfer(0, "after_reset", 1'b0, 32'h1010, 32'h0, 4'h0, 5, 1'b0, 32'h55AA55AA, 0, 1);
    go_idle(0);

    // Zero-wait instance: 8 back-to-back writes up to the last word, then reads.
    for (int i = 0; i < 8; i++)
      xfer(1, $sformatf("ws0_wr%0d", i), 1'b1, 32'h1FE0 + 32'(4*i), 32'hA500_0000 + 32'(i),
           4'hF, 3, 1'b0, 32'h0, 1, 0);
    chk("ws0 last mem_address", 64'(last_addr[1]), 64'd1023);
    for (int i = 0; i < 8; i++)
      xfer(1, $sformatf("ws0_rd%0d", i), 1'b0, 32'h1FE0 + 32'(4*i), 32'h0,
           4'h0, 3, 1'b0, 32'hA500_0000 + 32'(i), 0, 1);
    xfer(1, "ws0_rd_2000", 1'b0, 32'h2000, 32'h0, 4'h0, 2, 1'b1, 32'h0, 0, 0);
    go_idle(1);
    step(); step();

    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
